// File: rtl/encoder4to2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encoder4to2_pkg
// Description : Shared types and constants for the 4-to-2 encoder with ack.
// Revision    : 1.0 - initial release
// ============================================================================
package encoder4to2_pkg;

    // Presentation state: IDLE selects a request, HOLD keeps the code stable
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

    localparam int CODE_W = 2;
    localparam int REQ_N  = 4;

endpackage : encoder4to2_pkg
`default_nettype wire

// File: rtl/decoder2to4withEnable.sv
`default_nettype none
// ============================================================================
// Module      : decoder2to4withEnable
// Description : 2-to-4 one-hot decoder with enable; all-zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder2to4withEnable
    import encoder4to2_pkg::*;
(
    input  logic             i1,
    input  logic             i0,
    input  logic             En,
    output logic [REQ_N-1:0] o_y
);

    // One-hot of {i1,i0} gated by En
    always_comb begin
        o_y = '0;
        if (En) begin
            o_y = 4'b0001 << {i1, i0};
        end
    end

endmodule : decoder2to4withEnable
`default_nettype wire

// File: rtl/prio_enc4to2.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc4to2
// Description : Combinational 4-bit priority encoder, bit 3 highest priority.
//               o_any flags a non-zero input; o_code is the winning index.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc4to2
    import encoder4to2_pkg::*;
(
    input  logic [REQ_N-1:0]  i_req,
    output logic              o_any,
    output logic [CODE_W-1:0] o_code
);

    // Highest set index wins; code defaults to 0 when nothing is requested
    always_comb begin
        o_any  = |i_req;
        o_code = 2'd0;
        if (i_req[3]) begin
            o_code = 2'd3;
        end else if (i_req[2]) begin
            o_code = 2'd2;
        end else if (i_req[1]) begin
            o_code = 2'd1;
        end else begin
            o_code = 2'd0;
        end
    end

endmodule : prio_enc4to2
`default_nettype wire

// File: rtl/encoder4to2_with_ack.sv
`default_nettype none
// ============================================================================
// Module      : encoder4to2_with_ack
// Description : Registered 4-to-2 priority encoder. Requests are latched into
//               a pending register; the highest pending index is presented
//               with Valid and held until Ack, which clears that pending bit.
//               A new request on the same edge as the clear keeps the bit.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder4to2_with_ack
    import encoder4to2_pkg::*;
(
    input  logic             Clk,
    input  logic             RstN,
    input  logic             En,
    input  logic             i3,
    input  logic             i2,
    input  logic             i1,
    input  logic             i0,
    input  logic             Ack,
    output logic             o1,
    output logic             o0,
    output logic             Valid,
    output logic [REQ_N-1:0] Pend
);

    enc_state_t          r_state;
    enc_state_t          w_state_nxt;
    logic [REQ_N-1:0]    r_pend;
    logic [CODE_W-1:0]   r_code;

    logic [REQ_N-1:0]    w_set;
    logic [REQ_N-1:0]    w_cand;
    logic [REQ_N-1:0]    w_clr;
    logic                w_any;
    logic [CODE_W-1:0]   w_sel_code;
    logic                w_valid;
    logic                w_load;
    logic                w_ack_acc;

    // Requests only count while capture is enabled
    assign w_set  = {i3, i2, i1, i0} & {REQ_N{En}};
    // Selection sees this edge's requests as well as what is already pending
    assign w_cand = r_pend | w_set;

    prio_enc4to2 u_prio (
        .i_req  (w_cand),
        .o_any  (w_any),
        .o_code (w_sel_code)
    );

    // Clear one-hot for the presented code, only when an ack is accepted
    decoder2to4withEnable u_clr_dec (
        .i1  (r_code[1]),
        .i0  (r_code[0]),
        .En  (w_ack_acc),
        .o_y (w_clr)
    );

    // State register
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: leave IDLE on any candidate, leave HOLD on Ack
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_state_nxt = HOLD;
            HOLD:    if (Ack)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output/control decode from the registered state
    always_comb begin
        w_valid   = (r_state == HOLD);
        w_load    = (r_state == IDLE) && w_any;
        w_ack_acc = Ack && (r_state == HOLD);
    end

    // Code register: loaded only when a presentation starts, held otherwise
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_code <= '0;
        end else if (w_load) begin
            r_code <= w_sel_code;
        end
    end

    // Pending register: clear first, then set so a coincident request survives
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    assign o1    = r_code[1];
    assign o0    = r_code[0];
    assign Valid = w_valid;
    assign Pend  = r_pend;

endmodule : encoder4to2_with_ack
`default_nettype wire

// File: tb/tb_encoder4to2_with_ack.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder4to2_with_ack
// Description : Directed and random stimulus for encoder4to2_with_ack,
//               compared each cycle against a behavioural request model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder4to2_with_ack;

    logic       Clk;
    logic       RstN;
    logic       En;
    logic       i3, i2, i1, i0;
    logic       Ack;
    logic       o1, o0;
    logic       Valid;
    logic [3:0] Pend;

    int total = 0;
    int bad   = 0;

    // Behavioural model: set of pending lines, whether a code is shown, which
    bit [3:0] m_pend;
    bit       m_valid;
    bit [1:0] m_code;

    encoder4to2_with_ack dut (
        .Clk   (Clk),
        .RstN  (RstN),
        .En    (En),
        .i3    (i3),
        .i2    (i2),
        .i1    (i1),
        .i0    (i0),
        .Ack   (Ack),
        .o1    (o1),
        .o0    (o0),
        .Valid (Valid),
        .Pend  (Pend)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, {3'b0, Valid}, {3'b0, m_valid});
        check({tag, ".code"},  {2'b0, o1, o0}, {2'b0, m_code});
        check({tag, ".pend"},  Pend, m_pend);
    endtask

    // One rising edge as the specification describes it, applied to the model
    task automatic model_edge(input bit [3:0] req, input bit en, input bit ack);
        bit [3:0] setv;
        bit [3:0] nxt;
        bit [3:0] cand;
        setv = en ? req : 4'b0000;
        nxt  = m_pend;
        if (m_valid && ack) nxt[m_code] = 1'b0;
        nxt = nxt | setv;
        if (!m_valid) begin
            cand = m_pend | setv;
            if (cand != 4'b0000) begin
                for (int n = 0; n < 4; n++) if (cand[n]) m_code = n[1:0];
                m_valid = 1'b1;
            end
        end else if (ack) begin
            m_valid = 1'b0;
        end
        m_pend = nxt;
    endtask

    // Drive one cycle of inputs, clock it, and compare just after the edge
    task automatic cyc(input string tag, input logic [3:0] req, input logic en, input logic ack);
        {i3, i2, i1, i0} = req;
        En  = en;
        Ack = ack;
        model_edge(req, en, ack);
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        {i3, i2, i1, i0} = 4'b0000;
        En   = 1'b0;
        Ack  = 1'b0;
        RstN = 1'b1;
        #1 RstN = 1'b0;
        m_pend = 4'b0000; m_valid = 1'b0; m_code = 2'b00;
        repeat (2) @(posedge Clk);
        #3;
        check_all("reset");
        RstN = 1'b1;
        #1;

        // Single request, held without ack, then acked
        cyc("i2_req", 4'b0100, 1'b1, 1'b0);
        check("i2_code_const", {2'b0, o1, o0}, 4'b0010);
        for (int k = 0; k < 5; k++) cyc("i2_hold", 4'b0000, 1'b1, 1'b0);
        cyc("i2_ack", 4'b0000, 1'b1, 1'b1);
        check("i2_pend_empty", Pend, 4'b0000);

        // Three simultaneous requests drained with Ack tied high
        cyc("multi_0", 4'b1011, 1'b1, 1'b1);
        check("multi_first_code", {2'b0, o1, o0}, 4'b0011);
        for (int k = 0; k < 5; k++) cyc("multi_n", 4'b0000, 1'b1, 1'b1);
        check("multi_end_pend", Pend, 4'b0000);

        // Higher-priority request arriving during HOLD waits for the ack
        cyc("preempt_hold", 4'b0010, 1'b1, 1'b0);
        cyc("preempt_i3",   4'b1000, 1'b1, 1'b0);
        check("preempt_code_kept", {2'b0, o1, o0}, 4'b0001);
        cyc("preempt_ack",  4'b0000, 1'b1, 1'b1);
        cyc("preempt_next", 4'b0000, 1'b1, 1'b0);
        check("preempt_code_3", {2'b0, o1, o0}, 4'b0011);
        cyc("preempt_ack2", 4'b0000, 1'b1, 1'b1);

        // Request on the same edge as the ack keeps the bit pending
        cyc("setwin_hold", 4'b0010, 1'b1, 1'b0);
        cyc("setwin_ack",  4'b0010, 1'b1, 1'b1);
        check("setwin_pend1", Pend, 4'b0010);
        cyc("setwin_again", 4'b0000, 1'b1, 1'b0);
        cyc("setwin_ack2",  4'b0000, 1'b1, 1'b1);

        // Capture disabled, then a spurious ack in IDLE
        for (int k = 0; k < 4; k++) cyc("en0", 4'b1000, 1'b0, 1'b0);
        cyc("idle_ack", 4'b0000, 1'b0, 1'b1);
        check("idle_ack_valid", {3'b0, Valid}, 4'b0000);

        // Asynchronous reset in the middle of HOLD with Pend=1010
        cyc("pre_rst", 4'b1010, 1'b1, 1'b0);
        check("pre_rst_pend", Pend, 4'b1010);
        {i3, i2, i1, i0} = 4'b0000;
        #2 RstN = 1'b0;
        #1;
        m_pend = 4'b0000; m_valid = 1'b0; m_code = 2'b00;
        check_all("async_rst");
        @(posedge Clk);
        #3 RstN = 1'b1;
        for (int k = 0; k < 3; k++) cyc("post_rst", 4'b0000, 1'b1, 1'b0);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            logic [3:0] r;
            logic       e;
            logic       a;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) r = 4'b0000;
            e = ($urandom_range(0, 4) != 0);
            a = 1'($urandom);
            cyc("rand", r, e, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_encoder4to2_with_ack
`default_nettype wire
